// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- load/store unit for the memory-access stage.
//
// Takes the ALU result from execute. For memory ops it is the effective
// address; otherwise it is the writeback value. The unit runs a
// req/gnt/rvalid handshake with data memory. It aligns store data into byte
// lanes, generates write strobes, and sign/zero-extends load data. Each
// accepted instruction produces exactly one registered writeback beat.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   ex_valid / ex_ready        execute handshake (ready == state IDLE)
//   ex_alu_res, ex_mem_op      address-or-data, memory op code
//   ex_st_data, ex_rd, ex_we   store source, destination reg, reg write enable
//   dm_req/addr/wstrb/wdata    registered memory request
//   dm_gnt, dm_rvalid, dm_rdata memory grant and load response
//   wb_valid/we/rd/data/ale    registered writeback beat, ale = misaligned
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_res,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_st_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_we,
   output logic        dm_req,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_wstrb,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_ale
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t      state_reg;
   logic [31:0] addr_reg;
   logic [4:0]  rd_reg;
   logic        we_reg;
   logic        load_reg;
   logic [1:0]  size_reg;
   logic        sext_reg;

   // Decode of the incoming op
   logic        dec_load;
   logic        dec_store;
   logic [1:0]  dec_size;
   logic        dec_sext;
   logic        dec_mem;
   logic        dec_misaligned;

   always_comb begin
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_size  = SZ_B;
      dec_sext  = 1'b0;
      case (ex_mem_op)
         4'b1000: begin dec_load  = 1'b1; dec_size = SZ_B; dec_sext = 1'b1; end
         4'b1001: begin dec_load  = 1'b1; dec_size = SZ_H; dec_sext = 1'b1; end
         4'b1010: begin dec_load  = 1'b1; dec_size = SZ_W;                  end
         4'b1100: begin dec_load  = 1'b1; dec_size = SZ_B;                  end
         4'b1101: begin dec_load  = 1'b1; dec_size = SZ_H;                  end
         4'b0100: begin dec_store = 1'b1; dec_size = SZ_B;                  end
         4'b0101: begin dec_store = 1'b1; dec_size = SZ_H;                  end
         4'b0110: begin dec_store = 1'b1; dec_size = SZ_W;                  end
         default: begin dec_load  = 1'b0; dec_store = 1'b0;                end
      endcase
   end

   assign dec_mem        = dec_load | dec_store;
   assign dec_misaligned = ((dec_size == SZ_H) && ex_alu_res[0]) ||
                           ((dec_size == SZ_W) && (ex_alu_res[1:0] != 2'b00));

   // Per-lane strobe and store data. Halves replicate across the two halfword
   // lanes, and bytes replicate across all four lanes, so memory can pick any
   // lane selected by the strobe.
   logic [3:0]  st_strb;
   logic [31:0] st_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign st_strb[gi] = (dec_size == SZ_W) ||
                              ((dec_size == SZ_H) && (ex_alu_res[1] == 1'(gi / 2))) ||
                              ((dec_size == SZ_B) && (ex_alu_res[1:0] == 2'(gi)));
         assign st_wdata[8*gi +: 8] = (dec_size == SZ_W) ? ex_st_data[8*gi +: 8] :
                                      (dec_size == SZ_H) ? ex_st_data[8*(gi % 2) +: 8] :
                                                           ex_st_data[7:0];
      end
   endgenerate

   // Load extraction uses the latched address offset and the live response word
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   assign ld_byte = dm_rdata[{addr_reg[1:0], 3'b000} +: 8];
   assign ld_half = dm_rdata[{addr_reg[1], 4'b0000} +: 16];

   always_comb begin
      ld_value = dm_rdata;
      case (size_reg)
         SZ_B:    ld_value = {{24{sext_reg & ld_byte[7]}}, ld_byte};
         SZ_H:    ld_value = {{16{sext_reg & ld_half[15]}}, ld_half};
         default: ld_value = dm_rdata;
      endcase
   end

   assign ex_ready = (state_reg == S_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= S_IDLE;
         addr_reg  <= '0;
         rd_reg    <= '0;
         we_reg    <= 1'b0;
         load_reg  <= 1'b0;
         size_reg  <= SZ_B;
         sext_reg  <= 1'b0;
         dm_req    <= 1'b0;
         dm_addr   <= '0;
         dm_wstrb  <= '0;
         dm_wdata  <= '0;
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         wb_ale    <= 1'b0;
      end else begin
         // The beat is a single-cycle pulse. The other wb_* outputs hold.
         wb_valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (ex_valid) begin
                  addr_reg <= ex_alu_res;
                  rd_reg   <= ex_rd;
                  we_reg   <= ex_we;
                  load_reg <= dec_load;
                  size_reg <= dec_size;
                  sext_reg <= dec_sext;
                  if (!dec_mem) begin
                     wb_valid <= 1'b1;
                     wb_we    <= ex_we;
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_alu_res;
                     wb_ale   <= 1'b0;
                  end else if (dec_misaligned) begin
                     // Faulting access never reaches memory; report the address
                     wb_valid <= 1'b1;
                     wb_we    <= 1'b0;
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_alu_res;
                     wb_ale   <= 1'b1;
                  end else begin
                     state_reg <= S_REQ;
                     dm_req    <= 1'b1;
                     dm_addr   <= {ex_alu_res[31:2], 2'b00};
                     dm_wstrb  <= dec_store ? st_strb : 4'b0000;
                     dm_wdata  <= dec_store ? st_wdata : 32'h0;
                  end
               end
            end
            S_REQ: begin
               if (dm_gnt) begin
                  dm_req <= 1'b0;
                  if (load_reg) begin
                     state_reg <= S_WAIT;
                  end else begin
                     state_reg <= S_IDLE;
                     wb_valid  <= 1'b1;
                     wb_we     <= 1'b0;
                     wb_rd     <= rd_reg;
                     wb_data   <= addr_reg;
                     wb_ale    <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (dm_rvalid) begin
                  state_reg <= S_IDLE;
                  wb_valid  <= 1'b1;
                  wb_we     <= we_reg;
                  wb_rd     <= rd_reg;
                  wb_data   <= ld_value;
                  wb_ale    <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the memory-access stage of the pipelined CPU, directly downstream of the ALU.

- Consumes the ALU result from the execute stage: an effective address for memory ops, a writeback value otherwise.
- Runs a request/grant/response handshake with data memory for loads and stores.
- Performs byte/half alignment, write-strobe generation and load sign/zero extension.
- Presents one writeback beat per accepted instruction and stalls execute while a memory transaction is outstanding.

## Interface

Parameters: none; all widths fixed at 32-bit data/address, 5-bit register index.

- clk  in  1  single clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  unit accepts this cycle; high exactly when state is IDLE
- ex_alu_res  in  32  ALU result; address for memory ops, writeback data otherwise
- ex_mem_op  in  4  0000 NONE, 1000 LD_B, 1001 LD_H, 1010 LD_W, 1100 LD_BU, 1101 LD_HU, 0100 ST_B, 0101 ST_H, 0110 ST_W; any other code is treated as NONE
- ex_st_data  in  32  store source register value
- ex_rd  in  5  destination register
- ex_we  in  1  register write enable
- dm_req  out  1  memory request
- dm_addr  out  32  word address: {addr[31:2],2'b00}
- dm_wstrb  out  4  byte write strobes; 0000 for loads
- dm_wdata  out  32  replicated store data
- dm_gnt  in  1  memory accepts request this cycle
- dm_rvalid  in  1  load data valid
- dm_rdata  in  32  load data word
- wb_valid  out  1  one-cycle writeback beat
- wb_we  out  1  register write enable for the beat
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- wb_ale  out  1  misaligned-access exception flag, qualified by wb_valid

## Operation

- States: IDLE, REQ, WAIT.
- Accept on a rising edge where ex_valid && ex_ready. Latch addr, op, st_data, rd and we.
- **NONE op:** stay IDLE. Next cycle: wb_valid=1, wb_data=ex_alu_res, wb_we=ex_we, wb_rd=ex_rd.
- **Misaligned op:** H ops with addr[0]=1, or W ops with addr[1:0]≠0.
  - No dm_req is issued; stay IDLE.
  - Next cycle: wb_valid=1, wb_ale=1, wb_we=0, wb_data=faulting address.
- **Aligned memory op:** go to REQ.
  - dm_req=1; dm_addr, dm_wstrb and dm_wdata stay stable until dm_gnt is sampled high.
- **REQ + dm_gnt:**
  - Store: go to IDLE. Next cycle: wb_valid=1, wb_we=0, wb_data=address.
  - Load: go to WAIT; dm_req drops.
- **WAIT + dm_rvalid:** go to IDLE. Next cycle: wb_valid=1, wb_we=latched we, wb_data=extracted value.
- Store strobes and data:
  - ST_B: wstrb = 0001 << addr[1:0]; wdata = {4{st_data[7:0]}}.
  - ST_H: wstrb = 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = {2{st_data[15:0]}}.
  - ST_W: wstrb = 1111; wdata = st_data.
- Load extraction:
  - Byte = dm_rdata[8*addr[1:0] +: 8]; half = dm_rdata[16*addr[1] +: 16].
  - LD_B and LD_H sign-extend; LD_BU and LD_HU zero-extend; LD_W passes the word through.
- dm_gnt is ignored outside REQ. dm_rvalid is ignored outside WAIT, including in the grant cycle.
- There is no writeback backpressure; a wb beat is never dropped or repeated.

## Timing

- **Reset:** state IDLE, ex_ready=1. dm_req, dm_addr, dm_wstrb, dm_wdata, wb_valid, wb_we, wb_rd, wb_data and wb_ale are all 0.
- Asserting rstn mid-transaction abandons the transaction. dm_req deasserts asynchronously, and no wb beat is produced for that instruction.
- **Latency from accept edge to wb_valid cycle:**
  - NONE or misaligned: 1 cycle.
  - Store: 2 cycles when gnt arrives in the first REQ cycle.
  - Load: 3 cycles when gnt and rvalid each arrive in their first eligible cycle.
  - Each extra cycle without gnt or rvalid adds 1 cycle.
- **Back-to-back:** ex_ready=1 during the wb_valid cycle, since the state is already IDLE, so sustained NONE ops flow at 1 per cycle.
- wb_* outputs are registered; they hold their last value when wb_valid=0, and wb_ale is 0 on every non-exception beat.
- dm_* outputs are registered and change only on an accept edge, a gnt edge or reset.

## Test plan

- **Reset and pass-through:** reset → ex_ready=1, dm_req=0 and wb_valid=0. Then NONE op with alu_res=0x1234_5678, rd=5, we=1 → next cycle wb_valid=1, wb_data=0x1234_5678, wb_rd=5.
- **Store byte with delayed grant:** ST_B, addr=0x103, st_data=0xAB → dm_addr=0x100, wstrb=1000, wdata=0xABAB_ABAB. Hold gnt=0 for 2 cycles: dm_* stay stable and ex_ready=0. gnt=1 → wb_valid one cycle later with wb_we=0.
- **Load extension:** dm_rdata=0x80FF_7F01.
  - LD_B at addr 0x0 → 0x0000_0001; LD_B at 0x2 → 0xFFFF_FFFF.
  - LD_HU at 0x2 → 0x0000_80FF; LD_H at 0x2 → 0xFFFF_80FF.
  - LD_W → 0x80FF_7F01.
- **Misaligned access:** LD_W at 0x102 → no dm_req; next cycle wb_valid=1, wb_ale=1, wb_we=0, wb_data=0x102. ST_H at 0x1 → same behaviour.
- **Spurious handshakes and reset mid-flight:**
  - dm_rvalid pulsed in IDLE and in the REQ grant cycle → no wb beat.
  - Load in WAIT with rstn asserted → dm_req=0, no wb beat, ex_ready=1 after release.
